// File: rtl/gen_delta_seq.sv
// gen_delta_seq: snapshots NPTS control points and an X displacement, then
// computes the NPTS-1 signed fixed-point slopes (C[k+1]-C[k]) * 2^DT_D / dm
// one segment at a time with a shared restoring divider. Each slope is
// streamed out as it completes and kept in a register file for readout.
// Assumes NUMW >= DT_I+DT_D and 2^AW >= NPTS-1.
module gen_delta_seq #(
    parameter int NPTS  = 16,
    parameter int DSIZE = 16,
    parameter int DT_I  = 8,
    parameter int DT_D  = 4,
    parameter int AW    = 4
) (
    input  logic                     clock,
    input  logic                     rst_n,
    input  logic                     cal_begin,
    input  logic [NPTS*DSIZE-1:0]    pts,
    input  logic [DSIZE-1:0]         dm,
    output logic                     cal_busy,
    output logic                     cal_valid,
    output logic                     div0,
    output logic                     delta_we,
    output logic [AW-1:0]            delta_idx,
    output logic [DT_I+DT_D-1:0]     delta_out,
    input  logic [AW-1:0]            rd_addr,
    output logic [DT_I+DT_D-1:0]     rd_data
);

    localparam int W     = DT_I + DT_D;
    localparam int NUMW  = DSIZE + 1 + DT_D;
    localparam int DEPTH = 2 ** AW;
    localparam int CW    = $clog2(NUMW);

    localparam logic [CW-1:0]   LAST_CNT = CW'(NUMW - 1);
    localparam logic [AW-1:0]   LAST_K   = AW'(NPTS - 2);
    localparam logic [AW:0]     NSEG     = (AW + 1)'(NPTS - 1);
    localparam logic [W-1:0]    MAXV     = {1'b0, {(W - 1){1'b1}}};
    localparam logic [NUMW-1:0] MAXQ     = {{(NUMW - W){1'b0}}, MAXV};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_DIV   = 3'd2,
        S_STORE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic [AW-1:0]           k_q, k_d;
    logic [NPTS*DSIZE-1:0]   pts_q, pts_d;
    logic [DSIZE-1:0]        dm_q, dm_d;
    logic                    div0_q, div0_d;
    logic [NUMW-1:0]         num_q, num_d;      // numerator in, quotient out
    logic [DSIZE-1:0]        rem_q, rem_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    sign_q, sign_d;
    logic                    nz_q, nz_d;        // dy != 0, used when dm == 0
    logic                    valid_q, valid_d;
    logic                    we_q, we_d;
    logic [AW-1:0]           idx_q, idx_d;
    logic [W-1:0]            out_q, out_d;
    logic [W-1:0]            rd_q, rd_d;
    logic [W-1:0]            mem_q [DEPTH];

    logic [DSIZE-1:0]        c_lo_s, c_hi_s;
    logic [DSIZE:0]          dy_s, mag_s;
    logic [DSIZE:0]          trial_s;
    logic                    ge_s;
    logic [W-1:0]            m_s, delta_s;
    logic                    wr_en_s;

    // Segment arithmetic: dy at DSIZE+1 bits, one divider step, saturated result.
    always_comb begin
        c_lo_s  = pts_q[32'(k_q) * DSIZE +: DSIZE];
        c_hi_s  = pts_q[(32'(k_q) + 32'd1) * DSIZE +: DSIZE];
        dy_s    = {1'b0, c_hi_s} - {1'b0, c_lo_s};
        mag_s   = dy_s[DSIZE] ? (~dy_s + {{DSIZE{1'b0}}, 1'b1}) : dy_s;
        trial_s = {rem_q, num_q[NUMW-1]};
        ge_s    = (trial_s >= {1'b0, dm_q});
        if (div0_q) begin
            m_s = nz_q ? MAXV : {W{1'b0}};
        end else if (num_q > MAXQ) begin
            m_s = MAXV;
        end else begin
            m_s = num_q[W-1:0];
        end
        delta_s = sign_q ? (~m_s + {{(W - 1){1'b0}}, 1'b1}) : m_s;
    end

    // Sequencer: snapshot on cal_begin, then LOAD/DIV/STORE per segment.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        pts_d   = pts_q;
        dm_d    = dm_q;
        div0_d  = div0_q;
        num_d   = num_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        sign_d  = sign_q;
        nz_d    = nz_q;
        we_d    = 1'b0;
        idx_d   = idx_q;
        out_d   = out_q;
        wr_en_s = 1'b0;
        if (cal_begin) begin
            pts_d   = pts;
            dm_d    = dm;
            div0_d  = (dm == {DSIZE{1'b0}});
            k_d     = {AW{1'b0}};
            state_d = S_LOAD;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_IDLE;
                end
                S_LOAD: begin
                    num_d   = {mag_s, {DT_D{1'b0}}};
                    rem_d   = {DSIZE{1'b0}};
                    cnt_d   = {CW{1'b0}};
                    sign_d  = dy_s[DSIZE];
                    nz_d    = (dy_s != {(DSIZE + 1){1'b0}});
                    state_d = S_DIV;
                end
                S_DIV: begin
                    num_d = {num_q[NUMW-2:0], ge_s};
                    rem_d = ge_s ? DSIZE'(trial_s - {1'b0, dm_q}) : DSIZE'(trial_s);
                    if (cnt_q == LAST_CNT) begin
                        state_d = S_STORE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_STORE: begin
                    wr_en_s = 1'b1;
                    we_d    = 1'b1;
                    idx_d   = k_q;
                    out_d   = delta_s;
                    if (k_q == LAST_K) begin
                        state_d = S_DONE;
                    end else begin
                        k_d     = k_q + AW'(1);
                        state_d = S_LOAD;
                    end
                end
                S_DONE: begin
                    state_d = S_DONE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
        valid_d = (state_d == S_DONE);
    end

    // Read port next value: in-range entries only, zero otherwise.
    always_comb begin
        if ({1'b0, rd_addr} < NSEG) begin
            rd_d = mem_q[rd_addr];
        end else begin
            rd_d = {W{1'b0}};
        end
    end

    // Control, divider and output registers.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            k_q     <= {AW{1'b0}};
            pts_q   <= {(NPTS * DSIZE){1'b0}};
            dm_q    <= {DSIZE{1'b0}};
            div0_q  <= 1'b0;
            num_q   <= {NUMW{1'b0}};
            rem_q   <= {DSIZE{1'b0}};
            cnt_q   <= {CW{1'b0}};
            sign_q  <= 1'b0;
            nz_q    <= 1'b0;
            valid_q <= 1'b0;
            we_q    <= 1'b0;
            idx_q   <= {AW{1'b0}};
            out_q   <= {W{1'b0}};
            rd_q    <= {W{1'b0}};
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            pts_q   <= pts_d;
            dm_q    <= dm_d;
            div0_q  <= div0_d;
            num_q   <= num_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            sign_q  <= sign_d;
            nz_q    <= nz_d;
            valid_q <= valid_d;
            we_q    <= we_d;
            idx_q   <= idx_d;
            out_q   <= out_d;
            rd_q    <= rd_d;
        end
    end

    // Slope storage; a STORE-cycle read still sees the previous value.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {W{1'b0}};
            end
        end else if (wr_en_s) begin
            mem_q[k_q] <= delta_s;
        end
    end

    assign cal_busy  = (state_q != S_IDLE) && (state_q != S_DONE);
    assign cal_valid = valid_q & ~cal_begin;
    assign div0      = div0_q;
    assign delta_we  = we_q;
    assign delta_idx = idx_q;
    assign delta_out = out_q;
    assign rd_data   = rd_q;

endmodule

// File: tb/tb_gen_delta_seq.sv
// Bench for gen_delta_seq: scenario tasks against a plain-arithmetic slope model.
module tb_gen_delta_seq;

    localparam int NPTS  = 16;
    localparam int DSIZE = 16;
    localparam int AW    = 4;
    localparam int W     = 12;
    localparam int NSEG  = NPTS - 1;
    localparam int SEGT  = 23;
    localparam int RUNT  = NSEG * SEGT;

    logic                  clock = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  cal_begin = 1'b0;
    logic [NPTS*DSIZE-1:0] pts = '0;
    logic [DSIZE-1:0]      dm = '0;
    logic                  cal_busy, cal_valid, div0, delta_we;
    logic [AW-1:0]         delta_idx;
    logic [W-1:0]          delta_out;
    logic [AW-1:0]         rd_addr = '0;
    logic [W-1:0]          rd_data;

    int           tests = 0;
    int           fails = 0;
    int           cpt [NPTS];
    logic [W-1:0] exp_d [NSEG];
    logic         exp_div0;

    always #5 clock = ~clock;

    gen_delta_seq dut (
        .clock     (clock),
        .rst_n     (rst_n),
        .cal_begin (cal_begin),
        .pts       (pts),
        .dm        (dm),
        .cal_busy  (cal_busy),
        .cal_valid (cal_valid),
        .div0      (div0),
        .delta_we  (delta_we),
        .delta_idx (delta_idx),
        .delta_out (delta_out),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data)
    );

    // Slope = dy*16/dm truncated toward zero, clipped to +-2047; dm==0 gives sign*2047.
    function automatic logic [W-1:0] model_delta(input int c0, input int c1, input int d);
        int dy;
        int m;
        dy = c1 - c0;
        if (d == 0) begin
            m = (dy == 0) ? 0 : 2047;
        end else begin
            m = ((dy < 0 ? -dy : dy) * 16) / d;
            if (m > 2047) m = 2047;
        end
        if (dy < 0) m = -m;
        return m[W-1:0];
    endfunction

    task automatic build_expect(input int d);
        for (int k = 0; k < NSEG; k++) exp_d[k] = model_delta(cpt[k], cpt[k+1], d);
        exp_div0 = (d == 0);
    endtask

    task automatic start_cal(input int d);
        build_expect(d);
        @(negedge clock);
        for (int k = 0; k < NPTS; k++) pts[k*DSIZE +: DSIZE] = DSIZE'(cpt[k]);
        dm = DSIZE'(d);
        cal_begin = 1'b1;
        #1;
        tests++;
        if (cal_valid !== 1'b0) begin
            fails++;
            $display("FAIL valid_drop: cal_valid=%b required 0 while cal_begin high", cal_valid);
        end
        @(negedge clock);
        cal_begin = 1'b0;
    endtask

    task automatic read_sweep(input string name);
        logic [W-1:0] want;
        for (int a = 0; a < 16; a++) begin
            @(negedge clock);
            rd_addr = AW'(a);
            @(negedge clock);
            want = (a < NSEG) ? exp_d[a] : '0;
            tests++;
            if (rd_data !== want) begin
                fails++;
                $display("FAIL %s rd[%0d]: got %03h required %03h", name, a, rd_data, want);
            end
        end
    endtask

    // Follows a run from the negedge just after the snapshot edge (cycle 0).
    task automatic check_run(input string name);
        int ns;
        ns = 0;
        for (int c = 0; c <= RUNT + 5; c++) begin
            if (c > 0) @(negedge clock);
            if (delta_we === 1'b1) begin
                tests++;
                if (ns >= NSEG) begin
                    fails++;
                    $display("FAIL %s extra_strobe: idx=%0d at cycle %0d, required none", name, delta_idx, c);
                end else if (delta_idx !== AW'(ns) || delta_out !== exp_d[ns] || c != SEGT * (ns + 1)) begin
                    fails++;
                    $display("FAIL %s strobe%0d: idx=%0d val=%03h cyc=%0d required idx=%0d val=%03h cyc=%0d",
                             name, ns, delta_idx, delta_out, c, ns, exp_d[ns], SEGT * (ns + 1));
                end
                ns++;
            end
            tests++;
            if (cal_valid !== (c >= RUNT) || cal_busy !== (c < RUNT)) begin
                fails++;
                $display("FAIL %s status cyc%0d: valid=%b busy=%b required valid=%b busy=%b",
                         name, c, cal_valid, cal_busy, c >= RUNT, c < RUNT);
            end
        end
        tests++;
        if (ns != NSEG || div0 !== exp_div0) begin
            fails++;
            $display("FAIL %s count: strobes=%0d div0=%b required %0d and %b", name, ns, div0, NSEG, exp_div0);
        end
        read_sweep(name);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clock);
        tests++;
        if ({cal_busy, cal_valid, div0, delta_we, delta_idx, delta_out, rd_data} !== '0) begin
            fails++;
            $display("FAIL reset: busy=%b valid=%b div0=%b we=%b idx=%0d out=%03h rd=%03h required all 0",
                     cal_busy, cal_valid, div0, delta_we, delta_idx, delta_out, rd_data);
        end
        rst_n = 1'b1;
        for (int k = 0; k < NSEG; k++) exp_d[k] = '0;
        read_sweep("reset_mem");
    endtask

    task automatic test_ramp();
        for (int k = 0; k < NPTS; k++) cpt[k] = 32 * k;
        start_cal(16);
        check_run("ramp");
    endtask

    task automatic test_saturation();
        for (int k = 0; k < NPTS; k++) cpt[k] = 95;
        cpt[0] = 100; cpt[2] = 3095;
        start_cal(16);
        check_run("saturation");
    endtask

    task automatic test_div0();
        for (int k = 0; k < NPTS; k++) cpt[k] = 1;
        cpt[0] = 5; cpt[1] = 9;
        start_cal(0);
        check_run("div0");
    endtask

    task automatic test_truncation();
        for (int k = 0; k < NPTS; k++) cpt[k] = 10;
        cpt[0] = 0;
        start_cal(3);
        check_run("trunc_pos");
        for (int k = 0; k < NPTS; k++) cpt[k] = 0;
        cpt[0] = 10;
        start_cal(3);
        check_run("trunc_neg");
    endtask

    task automatic test_wrap();
        for (int k = 0; k < NPTS; k++) cpt[k] = (k % 2 == 0) ? 65535 : 0;
        start_cal(65535);
        check_run("wrap_bigdm");
        start_cal(1);
        check_run("wrap_dm1");
    endtask

    task automatic test_random();
        int v;
        for (int r = 0; r < 3; r++) begin
            cpt[0] = int'($urandom_range(0, 65535));
            for (int k = 1; k < NPTS; k++) begin
                v = cpt[k-1] + int'($urandom_range(0, 600)) - 300;
                if ($urandom_range(0, 4) == 0) v = int'($urandom_range(0, 65535));
                if (v < 0) v = 0;
                if (v > 65535) v = 65535;
                cpt[k] = v;
            end
            start_cal(int'($urandom_range(0, 40)));
            check_run("random");
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < NPTS; k++) cpt[k] = 1000 - 7 * k;
        start_cal(5);
        for (int c = 0; c < 100; c++) begin
            @(negedge clock);
            tests++;
            if (cal_valid !== 1'b0) begin
                fails++;
                $display("FAIL restart_prevalid cyc%0d: cal_valid=%b required 0", c, cal_valid);
            end
        end
        for (int k = 0; k < NPTS; k++) cpt[k] = 200 + 13 * k * k;
        start_cal(9);
        check_run("restart");
    endtask

    task automatic test_async_reset();
        for (int k = 0; k < NPTS; k++) cpt[k] = 1000 * k;
        start_cal(7);
        rd_addr = '0;
        repeat (30) @(negedge clock);
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if ({cal_busy, cal_valid, div0, delta_we, delta_idx, delta_out, rd_data} !== '0) begin
            fails++;
            $display("FAIL async_reset: busy=%b valid=%b div0=%b we=%b idx=%0d out=%03h rd=%03h required all 0",
                     cal_busy, cal_valid, div0, delta_we, delta_idx, delta_out, rd_data);
        end
        @(negedge clock);
        rst_n = 1'b1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clock);
            tests++;
            if (cal_busy !== 1'b0 || delta_we !== 1'b0 || cal_valid !== 1'b0) begin
                fails++;
                $display("FAIL post_reset_idle cyc%0d: busy=%b we=%b valid=%b required 0 0 0",
                         c, cal_busy, delta_we, cal_valid);
            end
        end
        for (int k = 0; k < NSEG; k++) exp_d[k] = '0;
        read_sweep("post_reset_mem");
        start_cal(7);
        check_run("after_reset");
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_saturation();
        test_div0();
        test_truncation();
        test_wrap();
        test_random();
        test_back_to_back();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached before the summary");
        $fatal(1);
    end

endmodule
